serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
- Bit-serial signed add/subtract sequencer for the multiplier basic library.
- Latches two WIDTH-bit two's-complement operands and processes one bit per clock through a single full-adder cell built from two half-adder cells plus a carry flip-flop.
- Presents the result, carry and signed overflow with a start/ready/done handshake.
- Used wherever area matters more than latency, e.g. as the shared accumulate adder of a sequential shift-add multiplier.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk     input   1      rising-edge clock
rst     input   1      synchronous, active-high reset
start   input   1      request; sampled only when ready=1
sub     input   1      0: a+b, 1: a-b; sampled with start
a       input   WIDTH  operand A (two's complement); sampled with start
b       input   WIDTH  operand B (two's complement); sampled with start
ready   output  1      1 in IDLE only
busy    output  1      1 in RUN only
done    output  1      one-cycle pulse, 1 in DONE only
result  output  WIDTH  sum/difference; held stable from DONE until the next accepted start
cout    output  1      raw carry out of the MSB (for subtract: 1 = no borrow)
ovf     output  1      signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock domain; rst is synchronous, active-high, and takes priority over all other inputs.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0.
- Reset internals: operand shift registers=0, carry FF=0, bit counter=0.
- FSM states: IDLE, RUN, DONE.

Start acceptance (rising edge where state=IDLE and start=1):
- opA <= a
- opB <= sub ? ~b : b
- carry <= sub
- cnt <= 0
- state <= RUN
- result, cout and ovf keep their previous values until the next DONE.

RUN, each rising edge processes bit cnt:
- ha0(opA[0], opB[0]) -> s0, c0
- ha1(s0, carry) -> s, c1
- carry <= c0 | c1
- Shift: opA >>= 1, opB >>= 1, result shift register <= {s, acc[WIDTH-1:1]}.
- When cnt = WIDTH-2, capture the current carry as carry-into-MSB.
- When cnt = WIDTH-1:
  - state <= DONE
  - result <= final shifted value
  - cout <= c0|c1
  - ovf <= carry_into_msb ^ (c0|c1)
- Otherwise cnt <= cnt+1.

DONE:
- done=1 for exactly one cycle; the next edge moves unconditionally to IDLE.

Latency:
- start sampled at edge k; done=1 in the cycle after edge k+WIDTH.
- Back-to-back throughput is one operation per WIDTH+2 cycles.

Boundary conditions:
- start while busy or in DONE: ignored, not queued.
- a, b and sub changes after acceptance have no effect.
- rst asserted in any state (including mid-RUN): returns to IDLE with reset values on the next edge; no done pulse is issued for the aborted operation.
- start and rst high together: rst wins.
- Arithmetic wraps modulo 2^WIDTH; overflow is reported only via ovf and never saturated.
- Counter width: $clog2(WIDTH).

Test Plan (WIDTH=8):
- add 100+27 -> 8 cycles after start: done pulse for exactly 1 cycle, result=127 (0x7F), cout=0, ovf=0; ready returns the following cycle.
- add 100+28 -> result=0x80, ovf=1, cout=0; add 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
- sub 5-7 -> result=0xFE (-2), cout=0 (borrow), ovf=0; sub 0x80-1 -> result=0x7F, cout=1, ovf=1.
- Start 3+4, then at RUN cycle 3 pulse start with a=0x55, b=0x11 and hold new a/b -> ignored; result=7, exactly one done pulse, busy high for exactly 8 cycles.
- Start 50+50, assert rst at RUN cycle 4 for 1 cycle -> next cycle ready=1, busy=0, result=0, no done pulse; a subsequent start 9-3 -> result=6, cout=1, ovf=0.
- Two back-to-back operations, start held high continuously -> second accepted on the first IDLE edge after DONE, i.e. 10 cycles apart; result held stable between its done pulse and the next acceptance.

Source files
------------

// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master side requests operations; the slave side is the sequencer itself.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial signed add/subtract: one full-adder cell (two half adders plus a
// carry flip-flop) walks the operands LSB first, one bit per clock.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   op_a_reg, op_b_reg, acc_reg, result_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg, cout_reg, ovf_reg;

    logic               s0, c0, s, c1, carry_next, last_bit;
    logic [WIDTH-1:0]   acc_next;

    // ha0 adds the operand bits, ha1 folds in the stored carry.
    always_comb begin
        s0         = op_a_reg[0] ^ op_b_reg[0];
        c0         = op_a_reg[0] & op_b_reg[0];
        s          = s0 ^ carry_reg;
        c1         = s0 & carry_reg;
        carry_next = c0 | c1;
        acc_next   = {s, acc_reg[WIDTH-1:1]};
        last_bit   = (cnt_reg == LAST_BIT);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1; the +1 rides in on the carry.
                        op_a_reg  <= bus.a;
                        op_b_reg  <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    op_a_reg  <= op_a_reg >> 1;
                    op_b_reg  <= op_b_reg >> 1;
                    acc_reg   <= acc_next;
                    carry_reg <= carry_next;
                    if (last_bit) begin
                        // On the MSB step carry_reg still holds the carry into the MSB.
                        result_reg <= acc_next;
                        cout_reg   <= carry_next;
                        ovf_reg    <= carry_reg ^ carry_next;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready  = (state_reg == IDLE);
    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.ovf    = ovf_reg;
endmodule
